batch_stream: RTL and testbench
===============================

# batch_stream

Host-side stream engine that sits on the other end of the batch controller's src/dst handshake. It reads each sample's input words from a local buffer memory and streams them out as src beats with src_last. It then accepts the sample's result words on the dst stream and writes them back to the buffer. The sequence repeats for a programmed number of samples.

## Interface
- DW, 32, data width of buffer and streams
- AW, 16, buffer address width
- clk  in  1  clock
- rst  in  1  reset; one clock; asynchronous, active-high
- start  in  1  pulse; begins a batch when idle
- ss  in  12  last src index per sample (ss+1 words)
- ds  in  12  last dst index per sample (ds+1 words)
- nb  in  8  last sample index (nb+1 samples)
- src_base, dst_base  in  AW  buffer base addresses
- rd_en  out  1  buffer read strobe
- rd_addr  out  AW  read address
- rd_data  in  DW  read data, valid the cycle after rd_en
- src_valid  out  1  src beat valid
- src_data  out  DW  src beat data
- src_last  out  1  final beat of sample
- src_ready  in  1  consumer ready
- dst_valid  in  1  result beat valid
- dst_data  in  DW  result data
- dst_ready  out  1  engine ready for results
- wr_en  out  1  buffer write strobe (registered)
- wr_addr  out  AW  write address
- wr_data  out  DW  write data
- busy  out  1  batch in progress
- done  out  1  one-cycle pulse at batch end

## Operation
- States: IDLE, SEND, RECV, DONE.
- IDLE -> SEND on start. On this transition, latch ss/ds/nb/bases, clear the sample counter, and set rptr=src_base, wptr=dst_base. start is ignored outside IDLE.
- SEND: issue reads at rptr, one per cycle, rptr+1 each. Stop after ss+1 reads in this sample.
  - A 2-entry FIFO holds returned data.
  - Issue when count + inflight − pop < 2.
  - src_valid = FIFO non-empty; src_data = FIFO head.
  - A beat transfers on src_valid & src_ready.
  - src_last is high with the (ss+1)th beat of the sample.
- SEND -> RECV the cycle after the last beat transfers. dst_ready=1 throughout RECV, 0 elsewhere.
- RECV: each dst_valid & dst_ready produces, next cycle, wr_en=1, wr_addr=wptr, wr_data=dst_data; wptr+1.
- After ds+1 dst beats:
  - sample==nb: go to DONE.
  - Otherwise: sample+1 and go to SEND.
- rptr and wptr run continuously across samples. Sample k src occupies src_base+k·(ss+1) onward.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in SEND/RECV/DONE.
- Pointers wrap modulo 2^AW. The counters are 12/8-bit and compare for equality against the latched limits.
- ss=0 / ds=0: single-beat samples; src_last is set on every beat.
- dst_valid in non-RECV states: not accepted, no write.
- rst at any time: state IDLE, FIFO and inflight cleared, all outputs 0 asynchronously.

## Timing
- Reset values: rd_en, src_valid, src_last, dst_ready, wr_en, busy, done, err = 0. src_data, rd_addr, wr_addr, wr_data = 0.
- start sampled at edge T0:
  - T1: SEND, busy=1, rd_en=1 at src_base.
  - T2: data captured into the FIFO.
  - src_valid=1 from T2 edge onward (visible in cycle T2+).
- With src_ready held high, throughput is 1 beat/cycle.
- src_valid/src_data stay stable until the beat transfers.
- rd_en, rd_addr and dst_ready are combinational from registered state and counters. All other outputs are registered.
- Write latency is 1 cycle from the dst handshake.

## Configuration
- BATCH_STREAM_ERR_EN defined: adds output err (1 bit).
  - err is set, sticky, when dst_valid=1 outside RECV.
  - It is also set when src_ready falls while src_valid=1 and no transfer has occurred.
  - Cleared by rst or by an accepted start.
- Not defined: no err port; violations are silently ignored.

## Test plan
- ss=3, ds=1, nb=0, src_base=0x10, dst_base=0x80, src_ready/dst_valid always high -> reads 0x10–0x13, four src beats with src_last on the 4th, writes at 0x80/0x81, one done pulse, busy low afterwards.
- ss=2, ds=0, nb=2 -> reads 0x00–0x08 contiguous, src_last on beats 3/6/9, writes 0x80, 0x81, 0x82, done after 3rd write.
- src_ready toggled 1010… during SEND -> no beat lost or duplicated, data order matches memory, never more than 2 outstanding entries.
- src_base=0xFFFE, ss=3 -> rd_addr sequence FFFE, FFFF, 0000, 0001.
- rst asserted mid-RECV -> all outputs 0 immediately; a following start runs a clean batch from the base addresses.
- BATCH_STREAM_ERR_EN: dst_valid pulsed in SEND -> err=1 and no wr_en; next start clears err.

Source files
------------

// File: rtl/batch_stream.sv
// Host-side stream engine: reads per-sample source words from a buffer, streams them out as src beats,
// then writes the returned dst beats back. Optional sticky protocol-error output under BATCH_STREAM_ERR_EN.
module batch_stream #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 16,
  localparam int unsigned SW = 12,
  localparam int unsigned NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] ss,
  input  logic [SW-1:0] ds,
  input  logic [NW-1:0] nb,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  output logic          src_last,
  input  logic          src_ready,
  input  logic          dst_valid,
  input  logic [DW-1:0] dst_data,
  output logic          dst_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done
`ifdef BATCH_STREAM_ERR_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] ss_q, ds_q, rcnt, dcnt;
  logic [NW-1:0] nb_q, sample;
  logic [AW-1:0] rptr, wptr;
  logic          reads_done, inflight, inflight_last;
  logic [1:0]    cnt;
  logic [DW-1:0] fifo1_data;
  logic          fifo1_last;
  logic [1:0]    occ_c;
  logic          pop_c, issue_c, acc_c, last_dst_c, go_c;

  // Occupancy after this cycle's pop: FIFO entries plus the read still in flight.
  assign pop_c      = src_valid & src_ready;
  assign occ_c      = cnt + 2'(inflight) - 2'(pop_c);
  assign issue_c    = (state == SEND) && !reads_done && (occ_c < 2'd2);
  assign rd_en      = issue_c;
  assign rd_addr    = rptr;
  assign dst_ready  = (state == RECV);
  assign acc_c      = dst_valid & dst_ready;
  assign last_dst_c = acc_c && (dcnt == ds_q);
  assign go_c       = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = SEND;
      SEND: if (pop_c && src_last) state_nx = RECV;
      RECV: if (last_dst_c) state_nx = (sample == nb_q) ? DONE : SEND;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q          <= '0;
      ds_q          <= '0;
      nb_q          <= '0;
      rcnt          <= '0;
      dcnt          <= '0;
      sample        <= '0;
      rptr          <= '0;
      wptr          <= '0;
      reads_done    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      cnt           <= '0;
      fifo1_data    <= '0;
      fifo1_last    <= 1'b0;
      src_valid     <= 1'b0;
      src_data      <= '0;
      src_last      <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (go_c) begin
        ss_q       <= ss;
        ds_q       <= ds;
        nb_q       <= nb;
        rptr       <= src_base;
        wptr       <= dst_base;
        sample     <= '0;
        rcnt       <= '0;
        dcnt       <= '0;
        reads_done <= 1'b0;
      end

      if (issue_c) begin
        rptr <= rptr + AW'(1);
        rcnt <= rcnt + SW'(1);
        if (rcnt == ss_q) reads_done <= 1'b1;
      end
      inflight      <= issue_c;
      inflight_last <= issue_c && (rcnt == ss_q);

      // Two-entry FIFO: src_data/src_last form the head, fifo1 the second slot.
      case ({inflight, pop_c})
        2'b10: begin
          src_valid <= 1'b1;
          if (cnt == 2'd0) begin
            src_data <= rd_data;
            src_last <= inflight_last;
            cnt      <= 2'd1;
          end else begin
            fifo1_data <= rd_data;
            fifo1_last <= inflight_last;
            cnt        <= 2'd2;
          end
        end
        2'b01: begin
          if (cnt == 2'd2) begin
            src_data <= fifo1_data;
            src_last <= fifo1_last;
            cnt      <= 2'd1;
          end else begin
            src_valid <= 1'b0;
            src_last  <= 1'b0;
            cnt       <= 2'd0;
          end
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            src_data <= rd_data;
            src_last <= inflight_last;
          end else begin
            src_data   <= fifo1_data;
            src_last   <= fifo1_last;
            fifo1_data <= rd_data;
            fifo1_last <= inflight_last;
          end
        end
        default: ;
      endcase

      wr_en <= acc_c;
      if (acc_c) begin
        wr_addr <= wptr;
        wr_data <= dst_data;
        wptr    <= wptr + AW'(1);
        dcnt    <= dcnt + SW'(1);
      end
      // End of a sample's results: rearm the read side for the next sample.
      if (last_dst_c) begin
        dcnt <= '0;
        if (sample != nb_q) begin
          sample     <= sample + NW'(1);
          rcnt       <= '0;
          reads_done <= 1'b0;
        end
      end

      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
    end
  end

`ifdef BATCH_STREAM_ERR_EN
  logic src_ready_q, xfer_q, viol_c;

  assign viol_c = (dst_valid && (state != RECV)) ||
                  (src_valid && src_ready_q && !src_ready && !xfer_q);

  // Sticky error; an accepted start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ready_q <= 1'b0;
      xfer_q      <= 1'b0;
      err         <= 1'b0;
    end else begin
      src_ready_q <= src_ready;
      xfer_q      <= pop_c;
      if (go_c)        err <= 1'b0;
      else if (viol_c) err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_batch_stream.sv
// Self-checking bench for batch_stream: buffer memory model, randomized handshakes,
// expected beats/writes computed from the batch parameters.
module tb_batch_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] ss_i = '0, ds_i = '0;
  logic [7:0]  nb_i = '0;
  logic [15:0] sb_i = '0, db_i = '0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic        src_valid, src_last;
  logic [31:0] src_data;
  logic        src_ready = 1'b0;
  logic        dst_valid = 1'b0;
  logic [31:0] dst_data = '0;
  logic        dst_ready, wr_en, busy, done;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
`ifdef BATCH_STREAM_ERR_EN
  logic        err;
`endif

  batch_stream dut (
    .clk(clk), .rst(rst), .start(start), .ss(ss_i), .ds(ds_i), .nb(nb_i),
    .src_base(sb_i), .dst_base(db_i), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
`ifdef BATCH_STREAM_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  logic [15:0] rd_log[$];
  logic [32:0] beat_log[$];
  logic [47:0] wr_log[$];
  int          vectors = 0, errors = 0;
  int          rmode = 0, dmode = 0, cyc = 0, dcount = 0, done_cnt = 0;
  int          out_cnt = 0, max_out = 0;
  logic        dv_force = 1'b0, pend = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] dbase = '0;

  function automatic logic [31:0] dval(input int i);
    return dbase ^ (32'(i) * 32'h9E3779B9);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment: memory read port, src consumer, dst producer, and logging.
  always begin
    @(negedge clk);
    cyc++;
    rd_data = pend ? mem[paddr] : 32'h0;
    case (rmode)
      0: src_ready = 1'b1;
      1: src_ready = cyc[0];
      default: src_ready = ($urandom % 4) != 0;
    endcase
    case (dmode)
      0: dst_valid = 1'b1;
      1: dst_valid = cyc[0];
      2: dst_valid = ($urandom % 3) != 0;
      default: dst_valid = dv_force;
    endcase
    dst_data = dval(dcount);
    #1;
    if (rst) begin
      pend = 1'b0;
    end else begin
      pend = rd_en;
      paddr = rd_addr;
      if (rd_en) begin
        rd_log.push_back(rd_addr);
        out_cnt++;
      end
      if (src_valid && src_ready) begin
        beat_log.push_back({src_last, src_data});
        out_cnt--;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      if (dst_valid && dst_ready) dcount++;
      if (wr_en) wr_log.push_back({wr_addr, wr_data});
      if (done) done_cnt++;
    end
  end

  task automatic run_batch(input int ss, input int ds, input int nb,
                           input logic [15:0] sb, input logic [15:0] db,
                           input int rm, input int dm, input bit chk_t1);
    int  nsrc, ndst, n;
    bit  got;
    nsrc = (nb + 1) * (ss + 1);
    ndst = (nb + 1) * (ds + 1);
    @(negedge clk);
    rd_log.delete(); beat_log.delete(); wr_log.delete();
    dcount = 0; done_cnt = 0; out_cnt = 0; max_out = 0;
    rmode = rm; dmode = dm; dbase = $urandom;
    ss_i = 12'(ss); ds_i = 12'(ds); nb_i = 8'(nb); sb_i = sb; db_i = db;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    if (chk_t1) begin
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_rd_en", 64'(rd_en), 64'd1);
      chk("t1_rd_addr", 64'(rd_addr), 64'(sb));
    end
    got = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      #2;
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("max_outstanding_le2", 64'(max_out <= 2), 64'd1);
    chk("rd_count", 64'(rd_log.size()), 64'(nsrc));
    chk("beat_count", 64'(beat_log.size()), 64'(nsrc));
    chk("wr_count", 64'(wr_log.size()), 64'(ndst));
    n = (rd_log.size() < nsrc) ? rd_log.size() : nsrc;
    for (int i = 0; i < n; i++)
      chk("rd_addr", 64'(rd_log[i]), 64'(16'(sb + 16'(i))));
    n = (beat_log.size() < nsrc) ? beat_log.size() : nsrc;
    for (int i = 0; i < n; i++) begin
      chk("src_data", 64'(beat_log[i][31:0]), 64'(mem[16'(sb + 16'(i))]));
      chk("src_last", 64'(beat_log[i][32]), 64'((i % (ss + 1)) == ss));
    end
    n = (wr_log.size() < ndst) ? wr_log.size() : ndst;
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", 64'(wr_log[i][47:32]), 64'(16'(db + 16'(i))));
      chk("wr_data", 64'(wr_log[i][31:0]), 64'(dval(i)));
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({pfx, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({pfx, "_src_valid"}, 64'(src_valid), 64'd0);
    chk({pfx, "_src_last"}, 64'(src_last), 64'd0);
    chk({pfx, "_src_data"}, 64'(src_data), 64'd0);
    chk({pfx, "_dst_ready"}, 64'(dst_ready), 64'd0);
    chk({pfx, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({pfx, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({pfx, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Directed batches
    run_batch(3, 1, 0, 16'h0010, 16'h0080, 0, 0, 1);
    run_batch(2, 0, 2, 16'h0000, 16'h0080, 0, 0, 1);
    run_batch(5, 2, 1, 16'h0100, 16'h0200, 1, 0, 1);
    run_batch(3, 1, 0, 16'hFFFE, 16'hFFFF, 0, 0, 1);
    run_batch(0, 0, 3, 16'h0300, 16'h0400, 1, 1, 1);

    // Randomized batches
    for (int t = 0; t < 5; t++)
      run_batch(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                16'($urandom), 16'($urandom), 2, 2, 0);

    // Reset in the middle of RECV, then a clean batch
    rmode = 0; dmode = 1;
    ss_i = 12'd1; ds_i = 12'd6; nb_i = 8'd0; sb_i = 16'h0040; db_i = 16'h0090;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (dst_ready) begin
        got = 1;
        break;
      end
    end
    chk("reach_recv", 64'(got), 64'd1);
    @(negedge clk); @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    run_batch(1, 6, 0, 16'h0040, 16'h0090, 0, 1, 1);

`ifdef BATCH_STREAM_ERR_EN
    // dst_valid during SEND flags err without a write; the next start clears it
    rmode = 0; dmode = 3; dv_force = 1'b0;
    ss_i = 12'd7; ds_i = 12'd1; nb_i = 8'd0; sb_i = 16'h0500; db_i = 16'h0600;
    wr_log.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); dv_force = 1'b1;
    @(negedge clk); dv_force = 1'b0;
    #2;
    chk("err_set", 64'(err), 64'd1);
    chk("err_no_write", 64'(wr_log.size()), 64'd0);
    dmode = 0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("err_batch_done", 64'(got), 64'd1);
    chk("err_sticky", 64'(err), 64'd1);
    dmode = 3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #2;
    chk("err_cleared", 64'(err), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
